lfsr_seq_checker: RTL

//  Receive-side checker for the 4-bit Fibonacci LFSR generator. The generator updates as

---
 rtl/lfsr_seq_checker.sv | 136 +++++++++++++
 1 files changed

// File: rtl/lfsr_seq_checker.sv
// Receive-side PRBS checker: syncs a local Fibonacci LFSR to the incoming bit stream,
// declares lock, then free-runs the reference and counts bit errors.
module lfsr_seq_checker #(
  parameter int               WIDTH      = 4,
  parameter logic [WIDTH-1:0] TAPS       = 4'b1010,
  parameter int               LOCK_CNT   = 8,
  parameter int               LOSS_CNT   = 4,
  parameter int               CNT_W      = 16,
  parameter int               ALLOW_ZERO = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int FW = $clog2(WIDTH + 1);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);
  localparam logic [FW-1:0] FILL_LAST = FW'(WIDTH - 1);
  localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_CNT - 1);
  localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_CNT - 1);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic [FW-1:0]    fill, fill_n;
  logic [MW-1:0]    match, match_n;
  logic [LW-1:0]    miss, miss_n;
  logic             err;

  logic             exp_bit;
  logic [WIDTH-1:0] sr_in, sr_fr;
  logic             zero_in, zero_fr;

  assign exp_bit = ^(sr & TAPS);
  assign sr_in   = {sr[WIDTH-2:0], in_bit};
  assign sr_fr   = {sr[WIDTH-2:0], exp_bit};
  // An all-zero reference is a lock-up state of the LFSR; optionally refuse it.
  assign zero_in = (ALLOW_ZERO == 0) && (sr_in == '0);
  assign zero_fr = (ALLOW_ZERO == 0) && (sr_fr == '0);

  always_comb begin
    state_n = state;
    sr_n    = sr;
    fill_n  = fill;
    match_n = match;
    miss_n  = miss;
    err     = 1'b0;
    if (in_valid) begin
      case (state)
        SEARCH: begin
          sr_n = sr_in;
          if (fill == FILL_LAST) begin
            state_n = VERIFY;
            fill_n  = '0;
            match_n = '0;
          end else begin
            fill_n = fill + 1'b1;
          end
        end
        VERIFY: begin
          sr_n = sr_in;
          if (in_bit != exp_bit || zero_in) begin
            state_n = SEARCH;
            fill_n  = '0;
            match_n = '0;
          end else if (match == LOCK_LAST) begin
            state_n = LOCKED;
            match_n = '0;
            miss_n  = '0;
          end else begin
            match_n = match + 1'b1;
          end
        end
        LOCKED: begin
          // Reference free-runs; received bits are only compared, never loaded.
          sr_n = sr_fr;
          if (in_bit != exp_bit) begin
            err = 1'b1;
            if (miss == LOSS_LAST) begin
              state_n = SEARCH;
              fill_n  = '0;
              miss_n  = '0;
            end else begin
              miss_n = miss + 1'b1;
            end
          end else begin
            miss_n = '0;
            if (zero_fr) begin
              state_n = SEARCH;
              fill_n  = '0;
            end
          end
        end
        default: begin
          state_n = SEARCH;
          fill_n  = '0;
          match_n = '0;
          miss_n  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SEARCH;
      sr        <= '0;
      fill      <= '0;
      match     <= '0;
      miss      <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_n;
      sr        <= sr_n;
      fill      <= fill_n;
      match     <= match_n;
      miss      <= miss_n;
      locked    <= (state_n == LOCKED);
      err_pulse <= err;
      if (clr_cnt)
        err_cnt <= err ? CNT_W'(1) : '0;
      else if (err && err_cnt != '1)
        err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule
